// File: rtl/div_2nbyn_seq.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, with valid/ready handshakes on the operand and result sides.
module div_2nbyn_seq #(
    parameter int N = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] dividend,
    input  logic [N-1:0]   divisor,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] quotient,
    output logic [N-1:0]   remainder,
    output logic           div_zero,
    output logic           q_fits_n
);
    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; in_ready depends on state only, out_valid holds until taken.
    localparam int CW = $clog2(2 * N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [2*N-1:0] d_reg;
    logic [2*N-1:0] q_reg;
    logic [N-1:0]   v_reg;
    logic [N:0]     r_reg;
    logic [CW-1:0]  count;

    logic [N:0]     t_val;
    logic           t_ge;
    logic [N:0]     r_next;
    logic [2*N-1:0] q_next;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next = (divisor == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One restoring step: the partial remainder stays below 2*V, so N+1 bits hold it.
    always_comb begin
        t_val  = {r_reg[N-1:0], d_reg[2*N-1]};
        t_ge   = (t_val >= {1'b0, v_reg});
        r_next = t_ge ? (t_val - {1'b0, v_reg}) : t_val;
        q_next = {q_reg[2*N-2:0], t_ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_reg     <= '0;
            q_reg     <= '0;
            v_reg     <= '0;
            r_reg     <= '0;
            count     <= '0;
            quotient  <= '0;
            remainder <= '0;
            div_zero  <= 1'b0;
            q_fits_n  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        d_reg <= dividend;
                        v_reg <= divisor;
                        r_reg <= '0;
                        q_reg <= '0;
                        count <= CW'(2 * N - 1);
                        if (divisor == '0) begin
                            quotient  <= '1;
                            remainder <= '0;
                            div_zero  <= 1'b1;
                            q_fits_n  <= 1'b0;
                        end
                    end
                end
                CALC: begin
                    d_reg <= {d_reg[2*N-2:0], 1'b0};
                    r_reg <= r_next;
                    q_reg <= q_next;
                    if (count == '0) begin
                        quotient  <= q_next;
                        remainder <= r_next[N-1:0];
                        div_zero  <= 1'b0;
                        q_fits_n  <= (q_next[2*N-1:N] == '0);
                    end else begin
                        count <= count - CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_2nbyn_seq.sv
// Bench for div_2nbyn_seq: directed table, backpressure and reset sequences,
// and an exhaustive operand sweep checked through an expected-result queue.
module tb_div_2nbyn_seq;
    localparam int N  = 4;
    localparam int DW = 2 * N;
    localparam int W  = DW + N + 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] dividend;
    logic [N-1:0]  divisor;
    logic          out_valid;
    wire           out_ready;
    logic [DW-1:0] quotient;
    logic [N-1:0]  remainder;
    logic          div_zero;
    logic          q_fits_n;

    logic          auto_ready = 1'b0;
    logic          man_ready  = 1'b0;
    logic          rnd_ready  = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] dd;
        logic [N-1:0]  dv;
        logic [DW-1:0] q;
        logic [N-1:0]  r;
        logic          dz;
        logic          fit;
    } vec_t;
    vec_t tbl[8];

    div_2nbyn_seq #(.N(N)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .dividend(dividend),
        .divisor(divisor),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .quotient(quotient),
        .remainder(remainder),
        .div_zero(div_zero),
        .q_fits_n(q_fits_n)
    );

    // Clock / reset
    always #5 clk = ~clk;

    always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);
    assign out_ready = auto_ready ? rnd_ready : man_ready;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] model(input logic [DW-1:0] dd, input logic [N-1:0] dv);
        logic [DW-1:0] q;
        logic [N-1:0]  r;
        logic          dz;
        logic          fit;
        if (dv == '0) begin
            q = '1; r = '0; dz = 1'b1; fit = 1'b0;
        end else begin
            q   = dd / DW'(dv);
            r   = N'(dd % DW'(dv));
            dz  = 1'b0;
            fit = (q < DW'(1 << N));
        end
        return {q, r, dz, fit};
    endfunction

    // Scoreboard: every result handshake pops and compares one expectation
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(1), 32'(0));
            end else begin
                check("result", 32'({quotient, remainder, div_zero, q_fits_n}), 32'(exp_q.pop_front()));
            end
        end
    end

    // Driver tasks
    task automatic send(input logic [DW-1:0] dd, input logic [N-1:0] dv,
                        input logic [W-1:0] exp, input bit push, output bit ok);
        int waited = 0;
        ok = 1'b0;
        while (!in_ready && waited < 200) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'(0), 32'(1));
            return;
        end
        in_valid = 1'b1;
        dividend = dd;
        divisor  = dv;
        @(posedge clk); #1;
        in_valid = 1'b0;
        dividend = DW'($urandom);
        divisor  = N'($urandom);
        if (push) exp_q.push_back(exp);
        ok = 1'b1;
    endtask

    task automatic wait_drain();
        int waited = 0;
        while ((exp_q.size() != 0 || out_valid) && waited < 400) begin
            @(posedge clk); #1;
            waited++;
        end
        check("drain", 32'(exp_q.size() != 0 || out_valid), 32'(0));
    endtask

    initial begin
        bit ok;
        int lat;
        rst      = 1'b1;
        in_valid = 1'b0;
        dividend = '0;
        divisor  = '0;

        tbl[0] = '{8'hE1, 4'hF, 8'h0F, 4'h0, 1'b0, 1'b1};
        tbl[1] = '{8'd200, 4'd7, 8'h1C, 4'd4, 1'b0, 1'b0};
        tbl[2] = '{8'h55, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0};
        tbl[3] = '{8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 1'b1};
        tbl[4] = '{8'hAB, 4'h1, 8'hAB, 4'h0, 1'b0, 1'b0};
        tbl[5] = '{8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 1'b0};
        tbl[6] = '{8'h0E, 4'hF, 8'h00, 4'hE, 1'b0, 1'b1};
        tbl[7] = '{8'hFF, 4'h2, 8'h7F, 4'h1, 1'b0, 1'b0};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'(1));
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_quotient", 32'(quotient), 32'(0));
        check("rst_remainder", 32'(remainder), 32'(0));
        check("rst_flags", 32'({div_zero, q_fits_n}), 32'(0));
        @(posedge clk); #1;

        // Directed table with latency check
        auto_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(tbl[i].dd, tbl[i].dv, {tbl[i].q, tbl[i].r, tbl[i].dz, tbl[i].fit}, 1'b1, ok);
            if (ok) begin
                lat = 0;
                while (!out_valid && lat < 100) begin
                    @(posedge clk); #1;
                    lat++;
                end
                if (tbl[i].dv == '0) check("latency_dz", 32'(lat <= 1), 32'(1));
                else                 check("latency_calc", 32'(lat), 32'(DW));
            end
        end
        wait_drain();

        // Backpressure: result held while out_ready stays low
        auto_ready = 1'b0;
        man_ready  = 1'b0;
        send(8'd9, 4'hC, model(8'd9, 4'hC), 1'b1, ok);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 32'(1));
            check("stall_quotient", 32'(quotient), 32'(0));
            check("stall_remainder", 32'(remainder), 32'(9));
            check("stall_in_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk); #1;
        man_ready = 1'b1;
        @(posedge clk); #1;
        man_ready = 1'b0;
        check("release_in_ready", 32'(in_ready), 32'(1));
        check("release_out_valid", 32'(out_valid), 32'(0));
        check("release_data_kept", 32'({quotient, remainder}), 32'({8'h00, 4'h9}));
        auto_ready = 1'b1;
        send(8'h80, 4'h1, {8'h80, 4'h0, 1'b0, 1'b0}, 1'b1, ok);
        wait_drain();

        // Reset in the middle of a division
        auto_ready = 1'b0;
        send(8'hE1, 4'hF, '0, 1'b0, ok);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_in_ready", 32'(in_ready), 32'(1));
        check("midrst_out_valid", 32'(out_valid), 32'(0));
        check("midrst_outputs", 32'({quotient, remainder, div_zero, q_fits_n}), 32'(0));
        auto_ready = 1'b1;
        send(8'h31, 4'h7, {8'h07, 4'h0, 1'b0, 1'b1}, 1'b1, ok);
        wait_drain();

        // Exhaustive sweep with random stalls
        for (int i = 0; i < (1 << (3 * N)); i++) begin
            logic [DW-1:0] dd;
            logic [N-1:0]  dv;
            dd = DW'(i >> N);
            dv = N'(i);
            send(dd, dv, model(dd, dv), 1'b1, ok);
            if (!ok) break;
        end
        wait_drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
